hyperbus_cfg_arbiter: RTL

- Shares the HyperBus configuration register port between NumReq register-interface masters, e.g. a boot-time config loader and the SoC host.
- Sits directly in front of the config register file.
- Arbitrates round-robin and locks the grant for one complete transaction.
- Tolerates long stalls, because the config register file holds ready low while a HyperBus transfer is active. An optional watchdog aborts stalled accesses.

---
 rtl/hyperbus_pkg.sv | 28 ++
 rtl/hyperbus_cfg_arbiter_if.sv | 12 +
 rtl/hyperbus_cfg_rr_pick.sv | 27 ++
 rtl/hyperbus_cfg_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/hyperbus_pkg.sv
// Shared types and defaults for the HyperBus config-port arbiter.
package hyperbus_pkg;

  localparam int unsigned AddrWidth            = 32;
  localparam int unsigned DataWidth            = 32;
  localparam int unsigned StrbWidth            = DataWidth / 8;
  localparam int unsigned DefaultTimeoutCycles = 256;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 valid;
  } reg_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } reg_rsp_t;

endpackage

// File: rtl/hyperbus_cfg_arbiter_if.sv
// Register-interface bundle of NumPorts request/response lanes.
interface hyperbus_cfg_arbiter_if #(
  parameter int unsigned NumPorts = 1
);

  hyperbus_pkg::reg_req_t [NumPorts-1:0] req;
  hyperbus_pkg::reg_rsp_t [NumPorts-1:0] rsp;

  modport master (output req, input  rsp);
  modport slave  (input  req, output rsp);

endinterface

// File: rtl/hyperbus_cfg_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr_i, wrapping at NumReq.
module hyperbus_cfg_rr_pick #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_c,
  output logic              found_c
);

  int unsigned cand;

  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    cand    = 0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = (32'(ptr_i) + off) % NumReq;
      if (!found_c && valid_i[IdxW'(cand)]) begin
        found_c = 1'b1;
        idx_c   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/hyperbus_cfg_arbiter.sv
// Round-robin arbiter sharing the HyperBus config register port between NumReq masters.
// Optional stall watchdog enabled by defining HYPERBUS_CFG_ARB_TIMEOUT_EN.
module hyperbus_cfg_arbiter
  import hyperbus_pkg::*;
#(
  parameter  int unsigned NumReq        = 2,
  parameter  int unsigned TimeoutCycles = DefaultTimeoutCycles,
  localparam int unsigned IdxW          = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  hyperbus_cfg_arbiter_if.slave  mst_bus,
  hyperbus_cfg_arbiter_if.master cfg_bus,
  output logic                   busy_o,
  output logic [IdxW-1:0]        grant_idx_o,
  output logic                   timeout_o
);

  arb_state_e                  state_q, state_d;
  logic [IdxW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]             grant_idx_q, grant_idx_d;
  logic [NumReq-1:0]           req_valid;
  logic [IdxW-1:0]             pick_idx_c;
  logic                        pick_found_c;
  logic [IdxW-1:0]             next_ptr_c;
  reg_req_t                    gnt_req_c;
  reg_rsp_t                    cfg_rsp_c;
  reg_req_t                    cfg_req_c;
  reg_rsp_t [NumReq-1:0]       rsp_c;
  logic                        timeout_c;

`ifdef HYPERBUS_CFG_ARB_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TimeoutCycles);
  logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TimeoutCycles);
`endif

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_valid[i] = mst_bus.req[i].valid;
    end
  end

  hyperbus_cfg_rr_pick #(
    .NumReq (NumReq)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_c   (pick_idx_c),
    .found_c (pick_found_c)
  );

  assign next_ptr_c = (32'(grant_idx_q) == NumReq - 1) ? '0 : IdxW'(32'(grant_idx_q) + 1);
  assign gnt_req_c  = mst_bus.req[grant_idx_q];
  assign cfg_rsp_c  = cfg_bus.rsp[0];

  // Next-state and combinational bus steering.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    cfg_req_c   = '0;
    rsp_c       = '0;
    timeout_c   = 1'b0;
`ifdef HYPERBUS_CFG_ARB_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_found_c) begin
          grant_idx_d = pick_idx_c;
          state_d     = BUSY;
`ifdef HYPERBUS_CFG_ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        cfg_req_c = gnt_req_c;
        // A master dropping valid mid-access forfeits its grant without a response.
        if (!gnt_req_c.valid) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr_c;
        end else begin
          rsp_c[grant_idx_q] = cfg_rsp_c;
          if (cfg_rsp_c.ready) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr_c;
          end
`ifdef HYPERBUS_CFG_ARB_TIMEOUT_EN
          else if (stall_cnt_q == StallW'(TimeoutCycles - 1)) begin
            cfg_req_c.valid    = 1'b0;
            rsp_c[grant_idx_q] = '{rdata: '0, error: 1'b1, ready: 1'b1};
            timeout_c          = 1'b1;
            state_d            = IDLE;
            rr_ptr_d           = next_ptr_c;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst_i) begin
      cfg_req_c = '0;
      rsp_c     = '0;
      timeout_c = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
`ifdef HYPERBUS_CFG_ARB_TIMEOUT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
`ifdef HYPERBUS_CFG_ARB_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign cfg_bus.req = cfg_req_c;
  assign mst_bus.rsp = rsp_c;
  assign busy_o      = (state_q == BUSY);
  assign grant_idx_o = grant_idx_q;
  assign timeout_o   = timeout_c;

endmodule
